// File: rtl/dmem_lsu_pkg.sv
// Shared types and width helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

    localparam int unsigned ByteBits = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLd    = 3'd1,
        StSt    = 3'd2,
        StRmwRd = 3'd3,
        StRmwWr = 3'd4,
        StErr   = 3'd5
    } lsu_state_e;

    // Number of address bits selecting a byte within a word.
    function automatic int unsigned lane_bits(input int unsigned word_width);
        return $clog2(word_width / ByteBits);
    endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// Byte-lane extract with sign/zero extension, and byte-lane merge into a word.
module dmem_byte_lane
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned LANE_BITS  = lane_bits(WORD_WIDTH)
) (
    input  logic [WORD_WIDTH-1:0] word_i,
    input  logic [LANE_BITS-1:0]  lane_i,
    input  logic [ByteBits-1:0]   wbyte_i,
    input  logic                  signed_i,
    output logic [WORD_WIDTH-1:0] ext_o,
    output logic [WORD_WIDTH-1:0] merged_o
);

    logic [ByteBits-1:0] lane_byte;

    always_comb begin
        lane_byte = word_i[{lane_i, 3'b000} +: ByteBits];
        ext_o     = {{(WORD_WIDTH - ByteBits){signed_i & lane_byte[ByteBits-1]}}, lane_byte};
    end

    always_comb begin
        merged_o = word_i;
        merged_o[{lane_i, 3'b000} +: ByteBits] = wbyte_i;
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit bridging the core memory stage to a sync-read-address / sync-write
// data memory; byte stores use read-modify-write, misaligned word accesses error out.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_req_valid,
    output logic                  out_req_ready,
    input  logic                  in_req_we,
    input  logic                  in_req_byte,
    input  logic                  in_req_signed,
    input  logic [ADDR_WIDTH-1:0] in_req_addr,
    input  logic [WORD_WIDTH-1:0] in_req_wdata,
    output logic                  out_resp_valid,
    output logic [WORD_WIDTH-1:0] out_resp_data,
    output logic                  out_resp_err,
    output logic [ADDR_WIDTH-1:0] out_mem_addr_rd,
    output logic [ADDR_WIDTH-1:0] out_mem_addr_wr,
    output logic [WORD_WIDTH-1:0] out_mem_word,
    output logic                  out_mem_write_en,
    input  logic [WORD_WIDTH-1:0] in_mem_word
);

    localparam int unsigned LaneBits = lane_bits(WORD_WIDTH);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ByteBits-1:0]   wbyte_q, wbyte_d;
    logic                  byte_q, byte_d;
    logic                  signed_q, signed_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_err_q, resp_err_d;
    logic [WORD_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_wr_q, mem_addr_wr_d;
    logic [WORD_WIDTH-1:0] mem_word_q, mem_word_d;

    logic                  idle_like;
    logic                  accept;
    logic                  misaligned;
    logic [WORD_WIDTH-1:0] lane_ext;
    logic [WORD_WIDTH-1:0] lane_merged;

    // ERR lasts one cycle but already counts as idle so the core can issue in C1.
    assign idle_like  = (state_q == StIdle) || (state_q == StErr);
    assign accept     = in_req_valid & idle_like;
    assign misaligned = ~in_req_byte & (|in_req_addr[LaneBits-1:0]);

    assign out_req_ready    = idle_like;
    assign out_mem_addr_rd  = idle_like ? in_req_addr : addr_q;
    assign out_resp_valid   = resp_valid_q;
    assign out_resp_err     = resp_err_q;
    assign out_resp_data    = resp_data_q;
    assign out_mem_write_en = mem_we_q;
    assign out_mem_addr_wr  = mem_addr_wr_q;
    assign out_mem_word     = mem_word_q;

    dmem_byte_lane #(
        .WORD_WIDTH (WORD_WIDTH),
        .LANE_BITS  (LaneBits)
    ) u_byte_lane (
        .word_i   (in_mem_word),
        .lane_i   (addr_q[LaneBits-1:0]),
        .wbyte_i  (wbyte_q),
        .signed_i (signed_q),
        .ext_o    (lane_ext),
        .merged_o (lane_merged)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wbyte_d       = wbyte_q;
        byte_d        = byte_q;
        signed_d      = signed_q;
        resp_valid_d  = 1'b0;
        resp_err_d    = 1'b0;
        resp_data_d   = '0;
        mem_we_d      = 1'b0;
        mem_addr_wr_d = mem_addr_wr_q;
        mem_word_d    = mem_word_q;

        unique case (state_q)
            StIdle, StErr: begin
                state_d = StIdle;
                if (accept) begin
                    addr_d   = in_req_addr;
                    wbyte_d  = in_req_wdata[ByteBits-1:0];
                    byte_d   = in_req_byte;
                    signed_d = in_req_signed;
                    if (misaligned) begin
                        state_d      = StErr;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (!in_req_we) begin
                        state_d = StLd;
                    end else if (!in_req_byte) begin
                        state_d       = StSt;
                        mem_we_d      = 1'b1;
                        mem_addr_wr_d = {in_req_addr[ADDR_WIDTH-1:LaneBits], {LaneBits{1'b0}}};
                        mem_word_d    = in_req_wdata;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLd: begin
                state_d      = StIdle;
                resp_valid_d = 1'b1;
                resp_data_d  = byte_q ? lane_ext : in_mem_word;
            end
            StSt: begin
                state_d      = StIdle;
                resp_valid_d = 1'b1;
            end
            StRmwRd: begin
                state_d       = StRmwWr;
                mem_we_d      = 1'b1;
                mem_addr_wr_d = {addr_q[ADDR_WIDTH-1:LaneBits], {LaneBits{1'b0}}};
                mem_word_d    = lane_merged;
            end
            StRmwWr: begin
                state_d      = StIdle;
                resp_valid_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wbyte_q       <= '0;
            byte_q        <= 1'b0;
            signed_q      <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_data_q   <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_wr_q <= '0;
            mem_word_q    <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wbyte_q       <= wbyte_d;
            byte_q        <= byte_d;
            signed_q      <= signed_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_data_q   <= resp_data_d;
            mem_we_q      <= mem_we_d;
            mem_addr_wr_q <= mem_addr_wr_d;
            mem_word_q    <= mem_word_d;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu against a small behavioural data memory.
module tb_dmem_lsu;

    localparam int unsigned WW = 16;
    localparam int unsigned AW = 12;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_req_valid = 1'b0;
    logic          out_req_ready;
    logic          in_req_we = 1'b0;
    logic          in_req_byte = 1'b0;
    logic          in_req_signed = 1'b0;
    logic [AW-1:0] in_req_addr = '0;
    logic [WW-1:0] in_req_wdata = '0;
    logic          out_resp_valid;
    logic [WW-1:0] out_resp_data;
    logic          out_resp_err;
    logic [AW-1:0] out_mem_addr_rd;
    logic [AW-1:0] out_mem_addr_wr;
    logic [WW-1:0] out_mem_word;
    logic          out_mem_write_en;
    logic [WW-1:0] in_mem_word;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    dmem_lsu #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .in_req_valid     (in_req_valid),
        .out_req_ready    (out_req_ready),
        .in_req_we        (in_req_we),
        .in_req_byte      (in_req_byte),
        .in_req_signed    (in_req_signed),
        .in_req_addr      (in_req_addr),
        .in_req_wdata     (in_req_wdata),
        .out_resp_valid   (out_resp_valid),
        .out_resp_data    (out_resp_data),
        .out_resp_err     (out_resp_err),
        .out_mem_addr_rd  (out_mem_addr_rd),
        .out_mem_addr_wr  (out_mem_addr_wr),
        .out_mem_word     (out_mem_word),
        .out_mem_write_en (out_mem_write_en),
        .in_mem_word      (in_mem_word)
    );

    // Memory: address sampled on the edge, data valid combinationally next cycle.
    logic [WW-1:0] mem [0:2047];
    logic [AW-1:0] rd_addr_q = '0;

    always @(posedge clock) begin
        rd_addr_q <= out_mem_addr_rd;
        if (out_mem_write_en) mem[out_mem_addr_wr[AW-1:1]] <= out_mem_word;
    end
    assign in_mem_word = mem[rd_addr_q[AW-1:1]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic byt, input logic sgn,
                         input logic [AW-1:0] a, input logic [WW-1:0] d);
        in_req_valid  = v;
        in_req_we     = we;
        in_req_byte   = byt;
        in_req_signed = sgn;
        in_req_addr   = a;
        in_req_wdata  = d;
    endtask

    task automatic tick;
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        mem[12'h010 >> 1] = 16'hA55A;

        // Reset values
        tick;
        chk("rst_ready", out_req_ready, 1);
        chk("rst_resp_valid", out_resp_valid, 0);
        chk("rst_resp_err", out_resp_err, 0);
        chk("rst_write_en", out_mem_write_en, 0);
        chk("rst_resp_data", out_resp_data, 0);
        chk("rst_mem_word", out_mem_word, 0);
        chk("rst_addr_wr", out_mem_addr_wr, 0);
        reset_n = 1'b1;

        // Word load at 0x010
        tick;
        drive(1, 0, 0, 0, 12'h010, 0);
        #1;
        chk("wl_c0_ready", out_req_ready, 1);
        chk("wl_c0_addr_rd", out_mem_addr_rd, 12'h010);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("wl_c1_ready", out_req_ready, 0);
        chk("wl_c1_resp", out_resp_valid, 0);
        chk("wl_c1_we", out_mem_write_en, 0);
        tick;
        chk("wl_c2_resp", out_resp_valid, 1);
        chk("wl_c2_data", out_resp_data, 16'hA55A);
        chk("wl_c2_err", out_resp_err, 0);
        chk("wl_c2_ready", out_req_ready, 1);
        chk("wl_c2_we", out_mem_write_en, 0);

        // Signed byte load at 0x011, accepted in C2 of the previous load
        drive(1, 0, 1, 1, 12'h011, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("sbl_c1_resp", out_resp_valid, 0);
        chk("sbl_c1_data", out_resp_data, 0);
        tick;
        chk("sbl_c2_resp", out_resp_valid, 1);
        chk("sbl_c2_data", out_resp_data, 16'hFFA5);

        // Unsigned byte load at 0x010
        drive(1, 0, 1, 0, 12'h010, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        chk("ubl_c2_resp", out_resp_valid, 1);
        chk("ubl_c2_data", out_resp_data, 16'h005A);

        // Byte store 0x3C at 0x011
        drive(1, 1, 1, 0, 12'h011, 16'hBB3C);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("bs_c1_we", out_mem_write_en, 0);
        chk("bs_c1_ready", out_req_ready, 0);
        tick;
        chk("bs_c2_we", out_mem_write_en, 1);
        chk("bs_c2_addr_wr", out_mem_addr_wr, 12'h010);
        chk("bs_c2_word", out_mem_word, 16'h3C5A);
        chk("bs_c2_resp", out_resp_valid, 0);
        chk("bs_c2_ready", out_req_ready, 0);
        tick;
        chk("bs_c3_resp", out_resp_valid, 1);
        chk("bs_c3_we", out_mem_write_en, 0);
        chk("bs_c3_ready", out_req_ready, 1);
        chk("bs_c3_data", out_resp_data, 0);

        // Word load at 0x010 sees the merged word
        drive(1, 0, 0, 0, 12'h010, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        chk("rb_c2_data", out_resp_data, 16'h3C5A);
        tick;
        chk("rb_c3_resp_drop", out_resp_valid, 0);

        // Misaligned word load at 0x013
        drive(1, 0, 0, 0, 12'h013, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("mis_c1_resp", out_resp_valid, 1);
        chk("mis_c1_err", out_resp_err, 1);
        chk("mis_c1_data", out_resp_data, 0);
        chk("mis_c1_we", out_mem_write_en, 0);
        chk("mis_c1_ready", out_req_ready, 1);
        tick;
        chk("mis_c2_resp", out_resp_valid, 0);
        chk("mis_c2_err", out_resp_err, 0);

        // Word store 0x1234 at 0x020, then back-to-back load in C2
        drive(1, 1, 0, 0, 12'h020, 16'h1234);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("ws_c1_we", out_mem_write_en, 1);
        chk("ws_c1_addr_wr", out_mem_addr_wr, 12'h020);
        chk("ws_c1_word", out_mem_word, 16'h1234);
        chk("ws_c1_ready", out_req_ready, 0);
        tick;
        chk("ws_c2_resp", out_resp_valid, 1);
        chk("ws_c2_ready", out_req_ready, 1);
        chk("ws_c2_we", out_mem_write_en, 0);
        drive(1, 0, 0, 0, 12'h020, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        chk("ws_c3_ready", out_req_ready, 0);
        tick;
        chk("ws_c4_resp", out_resp_valid, 1);
        chk("ws_c4_data", out_resp_data, 16'h1234);

        // Byte store at 0x021 aborted by reset during RMW_WR
        drive(1, 1, 1, 0, 12'h021, 16'h0077);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        chk("ab_c2_we", out_mem_write_en, 1);
        chk("ab_c2_word", out_mem_word, 16'h7734);
        #1 reset_n = 1'b0;
        #1;
        chk("ab_rst_we", out_mem_write_en, 0);
        chk("ab_rst_word", out_mem_word, 0);
        chk("ab_rst_addr_wr", out_mem_addr_wr, 0);
        chk("ab_rst_ready", out_req_ready, 1);
        tick;
        reset_n = 1'b1;
        chk("ab_mem_kept", mem[12'h020 >> 1], 16'h1234);
        chk("ab_resp_none", out_resp_valid, 0);
        tick;
        chk("ab_ready_after", out_req_ready, 1);
        drive(1, 0, 0, 0, 12'h020, 0);
        tick;
        drive(0, 0, 0, 0, 0, 0);
        tick;
        chk("ab_reload", out_resp_data, 16'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that sits between the swt16 core's memory stage and the data memory. It turns single byte or word load/store requests into the memory's split read/write port protocol. That protocol has a read address sampled on the clock edge and read data valid combinationally in the following cycle, plus a synchronous write. Byte stores are done as read-modify-write, and misaligned word accesses are rejected.

## Interface
Parameters:
- WORD_WIDTH, 16, data word width in bits; 16 or 32 supported.
- ADDR_WIDTH, 12, byte address width.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_req_valid  in  1  request present.
- out_req_ready  out  1  unit idle and able to accept a request.
- in_req_we  in  1  1 = store, 0 = load.
- in_req_byte  in  1  1 = byte access, 0 = word access.
- in_req_signed  in  1  sign-extend byte loads; ignored otherwise.
- in_req_addr  in  ADDR_WIDTH  byte address.
- in_req_wdata  in  WORD_WIDTH  store data; byte stores use bits [7:0].
- out_resp_valid  out  1  one-cycle completion pulse.
- out_resp_data  out  WORD_WIDTH  load result; 0 for stores and errors.
- out_resp_err  out  1  misaligned word access; valid with out_resp_valid.
- out_mem_addr_rd  out  ADDR_WIDTH  memory read address.
- out_mem_addr_wr  out  ADDR_WIDTH  memory write address, lane bits forced to 0.
- out_mem_word  out  WORD_WIDTH  memory write data.
- out_mem_write_en  out  1  memory write strobe.
- in_mem_word  in  WORD_WIDTH  memory read data, valid one cycle after the address is sampled.

## Operation
- LANE_BITS = log2(WORD_WIDTH/8). The lane is addr[LANE_BITS-1:0]. Lane 0 holds bits [7:0] (little-endian).
- A request is accepted when in_req_valid & out_req_ready. The accepting cycle is C0. On acceptance the unit latches addr, wdata, we, byte and signed.
- out_mem_addr_rd = in_req_addr in IDLE, otherwise the latched address. The memory therefore samples the address on the acceptance edge.
- States:
  - IDLE: ready=1.
  - LD: load data valid.
  - ST: word write.
  - RMW_RD: byte store, read old word.
  - RMW_WR: byte store, write merged word.
  - ERR: misaligned access.
- Transitions from IDLE on accept:
  - Word access with nonzero lane bits → ERR.
  - Load → LD.
  - Word store → ST.
  - Byte store → RMW_RD.
- Transitions from the other states:
  - LD, ST and ERR → IDLE.
  - RMW_RD → RMW_WR.
  - RMW_WR → IDLE.
- LD: the word load result is in_mem_word. A byte load selects the lane and then zero- or sign-extends it. The result is registered into out_resp_data.
- ST: out_mem_write_en=1, out_mem_addr_wr = the word-aligned latched address, out_mem_word = latched wdata. All three are registered outputs.
- RMW_RD: the old word is captured and the selected lane is replaced with wdata[7:0]. RMW_WR writes the merged word.
- ERR: no memory write. out_resp_err=1 with the resp pulse.
- Requests arriving while ready=0 are ignored; the core must hold them.

## Timing
- Reset values: out_req_ready=1 (IDLE); out_resp_valid, out_resp_err and out_mem_write_en are 0; out_resp_data, out_mem_word and out_mem_addr_wr are 0.
- Word or byte load: out_resp_valid in C2. ready=0 in C1 and ready=1 in C2, so a new request can be accepted in C2.
- Word store: write_en high in C1, the memory updates at the end of C1, resp in C2.
- Byte store: write_en high in C2, resp in C3, ready=1 again in C3.
- Misaligned access: resp with err in C1 and ready=1 in C1.
- A load accepted in the cycle after a store completes reads the new data, because the write edge precedes the read sample edge.
- A reset assertion in any state forces IDLE and all outputs to reset values immediately. A write in flight is aborted, with no partial update.

## Structure
- Package dmem_lsu_pkg: state enum (IDLE, LD, ST, RMW_RD, RMW_WR, ERR) and the lane-width localparam derivation.
- Sub-module dmem_byte_lane: combinational lane extract with sign/zero extension, and lane merge. It is shared by the LD and RMW paths.

## Test plan
Memory preload: byte address 0x010 = 0xA55A.
- Word load at 0x010 → resp_valid in C2, data 0xA55A, err=0, write_en never high.
- Signed byte load at 0x011 → 0xFFA5. Unsigned byte load at 0x010 → 0x005A.
- Byte store 0x3C at 0x011 → write_en only in C2 with addr_wr 0x010 and word 0x3C5A. resp in C3. A following word load at 0x010 returns 0x3C5A.
- Word load at 0x013 → resp_valid and err=1 in C1, data 0, no write_en, ready back in C1.
- Word store 0x1234 at 0x020, then a word load at 0x020 accepted in C2 → load returns 0x1234 in C4.
- Byte store with reset_n pulled low during RMW_WR → write_en drops asynchronously, memory word unchanged, ready=1 after release.
